// File: rtl/json_cmd_pkg.sv
// Shared definitions for the rover JSON command link: ASCII codes, parser
// state/key enums, link format constants and small decimal helpers.
package json_cmd_pkg;

  // ASCII bytes that carry structure in a command line
  localparam logic [7:0] LBRACE = 8'h7B;
  localparam logic [7:0] RBRACE = 8'h7D;
  localparam logic [7:0] QUOTE  = 8'h22;
  localparam logic [7:0] COLON  = 8'h3A;
  localparam logic [7:0] COMMA  = 8'h2C;
  localparam logic [7:0] MINUS  = 8'h2D;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] SP     = 8'h20;

  // Key letters
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_R = 8'h52;

  // Link format, shared with the transmit side
  localparam int CMD_FRAC_DIGITS = 3;
  localparam int CMD_VAL_W       = 16;
  localparam int CMD_MAX_FRAME   = 64;
  localparam int CMD_T_MAX       = 255;

  // Accumulator width: holds an in-range value times 10 plus full scaling
  localparam int ACC_W   = 40;
  localparam int MAX_POW = 7;

  typedef enum logic [3:0] {
    S_IDLE, S_KEY_OQ, S_KEY_CHAR, S_KEY_CQ, S_COLON,
    S_VAL_START, S_VAL_INT, S_VAL_FRAC, S_EXP_NL, S_ERR_SKIP
  } state_e;

  typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R} key_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // v * 10^n for n in 0..MAX_POW-1
  function automatic logic [ACC_W-1:0] scale_pow10(input logic [ACC_W-1:0] v,
                                                   input logic [3:0] n);
    logic [ACC_W-1:0] r;
    r = v;
    for (int i = 0; i < MAX_POW; i++) begin
      if (4'(i) < n) r = r * ACC_W'(10);
    end
    return r;
  endfunction

endpackage

// File: rtl/json_num_acc.sv
// Decimal accumulator for one JSON number: collects digits, sign and the
// decimal point, saturates on overflow, and presents the scaled signed value.
module json_num_acc import json_cmd_pkg::*; #(
  parameter int FRAC_DIGITS = CMD_FRAC_DIGITS,
  parameter int VAL_W       = CMD_VAL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    dig_en,
  input  logic [3:0]              dig,
  input  logic                    neg_en,
  input  logic                    dot_en,
  input  logic                    fin,
  input  logic                    int_mode,
  output logic signed [VAL_W-1:0] value,
  output logic                    ovf,
  output logic                    has_digit
);

  localparam logic [ACC_W-1:0] LIM_VAL = ACC_W'((1 << (VAL_W - 1)) - 1);
  localparam logic [ACC_W-1:0] LIM_T   = ACC_W'(CMD_T_MAX);
  localparam logic [3:0]       FD      = 4'(FRAC_DIGITS);

  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_fcnt;
  logic             r_neg, r_frac, r_has, r_ovf;

  logic [ACC_W-1:0] w_acc_nx, w_scaled_nx, w_lim, w_mag, w_signed;
  logic [3:0]       w_fcnt_nx;
  logic             w_take, w_dig_ovf;

  // Next digit candidate, its overflow test, and the final scaled value.
  // Integer mode (the T key) skips fractional scaling and uses the 0..255 range.
  always_comb begin
    w_acc_nx    = r_acc * ACC_W'(10) + ACC_W'(dig);
    w_take      = !r_frac || (r_fcnt < FD);
    w_fcnt_nx   = r_frac ? (r_fcnt + 4'd1) : r_fcnt;
    w_lim       = int_mode ? LIM_T : LIM_VAL;
    w_scaled_nx = int_mode ? w_acc_nx : scale_pow10(w_acc_nx, FD - w_fcnt_nx);
    w_dig_ovf   = w_take && (w_scaled_nx > w_lim);
    w_mag       = int_mode ? r_acc : scale_pow10(r_acc, FD - r_fcnt);
    w_signed    = r_neg ? (~w_mag + ACC_W'(1)) : w_mag;
  end

  assign value     = w_signed[VAL_W-1:0];
  assign ovf       = r_ovf | (dig_en & w_dig_ovf);
  assign has_digit = r_has;

  // Digit accumulation; excess fraction digits are dropped, an out-of-range
  // digit leaves acc at its last in-range value and raises ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_fcnt <= '0;
      r_neg  <= 1'b0;
      r_frac <= 1'b0;
      r_has  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clr || fin) begin
      r_acc  <= '0;
      r_fcnt <= '0;
      r_neg  <= 1'b0;
      r_frac <= 1'b0;
      r_has  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (neg_en) r_neg <= 1'b1;
      if (dot_en) r_frac <= 1'b1;
      if (dig_en) begin
        r_has <= 1'b1;
        if (w_dig_ovf) begin
          r_ovf <= 1'b1;
        end else if (w_take) begin
          r_acc  <= w_acc_nx;
          r_fcnt <= w_fcnt_nx;
        end
      end
    end
  end

endmodule

// File: rtl/json_cmd_rx_parser.sv
// Byte-serial parser for {"T":n,"L":x,"R":y}\n command lines from uart_rx.
// Handshake: rx_valid is a one-cycle strobe with no backpressure; a byte is
// consumed on every cycle it is high. cmd_valid / frame_err are one-cycle
// pulses, registered one cycle after the byte that decides the frame.
module json_cmd_rx_parser import json_cmd_pkg::*; #(
  parameter int FRAC_DIGITS = CMD_FRAC_DIGITS,
  parameter int VAL_W       = CMD_VAL_W,
  parameter int MAX_FRAME   = CMD_MAX_FRAME
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_t,
  output logic signed [VAL_W-1:0] cmd_l,
  output logic signed [VAL_W-1:0] cmd_r,
  output logic [2:0]              cmd_fields,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int CNT_W = $clog2(MAX_FRAME + 2);

  state_e r_state, w_state_nx;
  key_e   r_key, w_key_nx;

  logic [7:0]       r_t, r_cmd_t;
  logic [VAL_W-1:0] r_l, r_r, r_cmd_l, r_cmd_r;
  logic [2:0]       r_mask, r_cmd_fields;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_valid, r_frame_err;

  logic w_is_dig, w_in_val, w_dig_en, w_int_mode, w_too_long, w_skip;
  logic w_neg_en, w_dot_en, w_store, w_err, w_done, w_restart, w_bad;
  logic w_acc_ovf, w_acc_has;
  logic signed [VAL_W-1:0] w_acc_val;

  assign w_is_dig   = is_digit(rx_data);
  assign w_in_val   = (r_state == S_VAL_START) || (r_state == S_VAL_INT) ||
                      (r_state == S_VAL_FRAC);
  assign w_dig_en   = rx_valid && w_is_dig && w_in_val;
  assign w_int_mode = (r_key == KEY_T);
  assign w_too_long = (r_cnt >= CNT_W'(MAX_FRAME));
  assign w_skip     = (rx_data == SP) || (rx_data == CR);

  json_num_acc #(.FRAC_DIGITS(FRAC_DIGITS), .VAL_W(VAL_W)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_restart),
    .dig_en    (w_dig_en),
    .dig       (rx_data[3:0]),
    .neg_en    (w_neg_en),
    .dot_en    (w_dot_en),
    .fin       (w_store),
    .int_mode  (w_int_mode),
    .value     (w_acc_val),
    .ovf       (w_acc_ovf),
    .has_digit (w_acc_has)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state and per-byte actions. Priority: resync on '{', length limit,
  // line end, whitespace skip, then the state-specific grammar.
  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_neg_en   = 1'b0;
    w_dot_en   = 1'b0;
    w_store    = 1'b0;
    w_err      = 1'b0;
    w_done     = 1'b0;
    w_restart  = 1'b0;
    w_bad      = 1'b0;
    if (rx_valid) begin
      if (r_state == S_IDLE) begin
        if (rx_data == LBRACE) begin
          w_restart  = 1'b1;
          w_state_nx = S_KEY_OQ;
        end
      end else if (rx_data == LBRACE) begin
        // A frame in ERR_SKIP has already been reported once
        w_err      = (r_state != S_ERR_SKIP);
        w_restart  = 1'b1;
        w_state_nx = S_KEY_OQ;
      end else if (r_state == S_ERR_SKIP) begin
        if (rx_data == LF) w_state_nx = S_IDLE;
      end else if (w_too_long) begin
        w_err      = 1'b1;
        w_state_nx = (rx_data == LF) ? S_IDLE : S_ERR_SKIP;
      end else if (rx_data == LF) begin
        w_done     = (r_state == S_EXP_NL);
        w_err      = (r_state != S_EXP_NL);
        w_state_nx = S_IDLE;
      end else if (!(w_skip && (r_state != S_KEY_CHAR))) begin
        w_bad = 1'b1;
        case (r_state)
          S_KEY_OQ: if (rx_data == QUOTE) begin
            w_bad = 1'b0; w_state_nx = S_KEY_CHAR;
          end
          S_KEY_CHAR: begin
            if (rx_data == CH_T && !r_mask[2]) begin
              w_bad = 1'b0; w_key_nx = KEY_T; w_state_nx = S_KEY_CQ;
            end else if (rx_data == CH_L && !r_mask[1]) begin
              w_bad = 1'b0; w_key_nx = KEY_L; w_state_nx = S_KEY_CQ;
            end else if (rx_data == CH_R && !r_mask[0]) begin
              w_bad = 1'b0; w_key_nx = KEY_R; w_state_nx = S_KEY_CQ;
            end
          end
          S_KEY_CQ: if (rx_data == QUOTE) begin
            w_bad = 1'b0; w_state_nx = S_COLON;
          end
          S_COLON: if (rx_data == COLON) begin
            w_bad = 1'b0; w_state_nx = S_VAL_START;
          end
          S_VAL_START: begin
            if (w_is_dig) begin
              w_bad = w_acc_ovf; w_state_nx = S_VAL_INT;
            end else if (rx_data == MINUS && !w_int_mode) begin
              w_bad = 1'b0; w_neg_en = 1'b1; w_state_nx = S_VAL_INT;
            end
          end
          S_VAL_INT, S_VAL_FRAC: begin
            if (w_is_dig) begin
              w_bad = w_acc_ovf;
            end else if (rx_data == DOT && r_state == S_VAL_INT && !w_int_mode) begin
              w_bad = 1'b0; w_dot_en = 1'b1; w_state_nx = S_VAL_FRAC;
            end else if ((rx_data == COMMA || rx_data == RBRACE) && w_acc_has) begin
              w_bad      = 1'b0;
              w_store    = 1'b1;
              w_state_nx = (rx_data == COMMA) ? S_KEY_OQ : S_EXP_NL;
            end
          end
          default: ;
        endcase
        if (w_bad) begin
          w_err      = 1'b1;
          w_state_nx = S_ERR_SKIP;
        end
      end
    end
  end

  // Working field registers, byte count, and the registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= KEY_T;
      r_t          <= '0;
      r_l          <= '0;
      r_r          <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_cmd_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cmd_t      <= '0;
      r_cmd_l      <= '0;
      r_cmd_r      <= '0;
      r_cmd_fields <= '0;
    end else begin
      r_key       <= w_key_nx;
      r_cmd_valid <= w_done;
      r_frame_err <= w_err;
      if (w_restart) begin
        r_t    <= '0;
        r_l    <= '0;
        r_r    <= '0;
        r_mask <= '0;
        r_cnt  <= CNT_W'(1);
      end else begin
        if (rx_valid && (r_state != S_IDLE) && (r_cnt <= CNT_W'(MAX_FRAME)))
          r_cnt <= r_cnt + CNT_W'(1);
        if (w_store) begin
          case (r_key)
            KEY_T:   begin r_t <= w_acc_val[7:0]; r_mask[2] <= 1'b1; end
            KEY_L:   begin r_l <= w_acc_val;      r_mask[1] <= 1'b1; end
            KEY_R:   begin r_r <= w_acc_val;      r_mask[0] <= 1'b1; end
            default: ;
          endcase
        end
      end
      if (w_done) begin
        r_cmd_t      <= r_t;
        r_cmd_l      <= r_l;
        r_cmd_r      <= r_r;
        r_cmd_fields <= r_mask;
      end
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign frame_err  = r_frame_err;
  assign cmd_t      = r_cmd_t;
  assign cmd_l      = r_cmd_l;
  assign cmd_r      = r_cmd_r;
  assign cmd_fields = r_cmd_fields;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_json_cmd_rx_parser.sv
// Testbench for json_cmd_rx_parser: table of frames with expected outcome,
// scoreboard queue of expected pulses, plus reset / long-frame / prefix cases.
module tb_json_cmd_rx_parser;

  localparam int W = 44; // {is_valid, t[8], l[16], r[16], fields[3]}

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic [7:0]  cmd_t;
  logic signed [15:0] cmd_l;
  logic signed [15:0] cmd_r;
  logic [2:0]  cmd_fields;
  logic        frame_err;
  logic        busy;

  json_cmd_rx_parser #(.FRAC_DIGITS(3), .VAL_W(16), .MAX_FRAME(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_t      (cmd_t),
    .cmd_l      (cmd_l),
    .cmd_r      (cmd_r),
    .cmd_fields (cmd_fields),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string frame;
    bit    ok;
    bit    lat;   // outcome decided by the final '\n'
    bit    b2b;   // next frame follows with no idle cycle
    int    t;
    int    l;
    int    r;
    int    f;
  } vec_t;

  vec_t vq[$];
  logic [W-1:0] exp_q[$];
  logic [7:0]  m_t;
  logic [15:0] m_l, m_r;
  logic [2:0]  m_f;
  int checks;
  int errors;

  // Scoreboard model: last good command held by the outputs
  task automatic push_ok(input int t, input int l, input int r, input int f);
    m_t = 8'(t); m_l = 16'(l); m_r = 16'(r); m_f = 3'(f);
    exp_q.push_back({1'b1, m_t, m_l, m_r, m_f});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b0, m_t, m_l, m_r, m_f});
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock step; any output pulse is matched against the scoreboard
  task automatic tick();
    logic [W-1:0] act;
    logic [W-1:0] exp;
    @(negedge clk);
    if (cmd_valid || frame_err) begin
      act = {cmd_valid, cmd_t, cmd_l, cmd_r, cmd_fields};
      checks++;
      if (cmd_valid && frame_err) begin
        errors++;
        $display("FAIL both_pulses: cmd_valid and frame_err high together at %0t", $time);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got %h expected no pulse", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", act, exp);
        end
      end
    end
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
  endtask

  task automatic idle();
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic add_vec(input string s, input bit ok, input bit lat, input bit b2b,
                         input int t, input int l, input int r, input int f);
    vec_t v;
    v.frame = s; v.ok = ok; v.lat = lat; v.b2b = b2b;
    v.t = t; v.l = l; v.r = r; v.f = f;
    vq.push_back(v);
  endtask

  localparam string TEST1 = "{\"T\":1,\"L\":0.5,\"R\":0.5}\n";

  initial begin
    checks = 0; errors = 0;
    m_t = '0; m_l = '0; m_r = '0; m_f = '0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset state
    repeat (3) tick();
    check_eq("reset_outputs", 64'({cmd_valid, frame_err, busy, cmd_t, cmd_l, cmd_r, cmd_fields}), 64'd0);
    rst_n = 1'b1;
    idle();

    // Frame table: frame, ok, lat, b2b, T, L, R, fields
    add_vec(TEST1,                                  1, 1, 0, 1, 500, 500, 7);
    add_vec("{\"T\":1,\"L\":-0.25,\"R\":0.25}\n",   1, 0, 1, 1, -250, 250, 7);
    add_vec("{\"T\":1,\"L\":-0.5,\"R\":-0.5}\n",    1, 1, 0, 1, -500, -500, 7);
    add_vec("{\"T\":1,\"L\":0.12345}\n",            1, 1, 0, 1, 123, 0, 6);
    add_vec("{\"X\":1}\n",                          0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"L\":40}\n",                         0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"T\":1,\"T\":2}\n",                  0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"R\":-32.767}\n",                    1, 1, 0, 0, 0, -32767, 1);
    add_vec("{\"L\":32.768}\n",                     0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"T\":255,\"L\":7}\n",                1, 1, 0, 255, 7000, 0, 6);
    add_vec("{\"T\":256}\n",                        0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"T\":-1}\n",                         0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"L\":-}\n",                          0, 0, 0, 0, 0, 0, 0);
    add_vec("{\"L\":}\n",                           0, 0, 0, 0, 0, 0, 0);
    add_vec("{ \"T\" : 3 , \"R\" : 1.5 }\015\n",    1, 1, 0, 3, 0, 1500, 5);
    add_vec("{\"T\":1\n",                           0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].ok) push_ok(vq[i].t, vq[i].l, vq[i].r, vq[i].f);
      else          push_err();
      send_str(vq[i].frame);
      if (!vq[i].b2b) begin
        idle();
        if (vq[i].lat)
          check_eq($sformatf("latency_%0d", i), 64'(cmd_valid | frame_err), 64'd1);
        idle();
      end
    end

    // Reset mid-frame: partial frame dropped silently, outputs cleared
    send_str("{\"T\":1,\"L\"");
    idle();
    check_eq("busy_mid_frame", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_frame", 64'({cmd_valid, frame_err, busy, cmd_t, cmd_l, cmd_r, cmd_fields}), 64'd0);
    m_t = '0; m_l = '0; m_r = '0; m_f = '0;
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    push_ok(1, 500, 500, 7);
    send_str(TEST1);
    idle();
    check_eq("latency_after_reset", 64'(cmd_valid), 64'd1);
    idle();

    // 70-byte frame of spaces exceeds the frame limit
    push_err();
    send_byte(8'h7B);
    for (int k = 0; k < 68; k++) send_byte(8'h20);
    send_byte(8'h0A);
    idle();
    check_eq("busy_after_long", 64'(busy), 64'd0);

    // Garbage prefix before a good frame is ignored
    push_ok(1, 500, 500, 7);
    send_str("ab}");
    send_str(TEST1);
    idle();
    check_eq("latency_prefix", 64'(cmd_valid), 64'd1);

    repeat (4) idle();
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
